// File: rtl/product_bcd_converter.sv
// product_bcd_converter: sequential double-dabble binary-to-packed-BCD converter, one bit per clock.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_bin accept a binary operand;
// out_valid/out_ready/bcd_out return packed BCD ([3:0]=ones); busy is high while shifting.
module product_bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_bin,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  if (longint'(10) ** DIGITS <= (longint'(1) << WIDTH) - longint'(1)) begin : g_digits_chk
    $error("DIGITS too small to hold 2**WIDTH-1");
  end
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [BW-1:0] acc_q, acc_d, adj, bcd_q, bcd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ready_q, ready_d, valid_q, valid_d, busy_q, busy_d;
  // add-3 correction on every digit that would overflow past 9 after the shift
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = acc_q[4*i +: 4] >= 4'd5 ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
  end
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: if (in_valid) begin
        op_d    = in_bin;
        acc_d   = '0;
        cnt_d   = CW'(WIDTH);
        state_d = SHIFT;
      end
      SHIFT: begin
        {acc_d, op_d} = {adj, op_q} << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          bcd_d   = acc_d;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // handshake outputs are registered images of the next state
    ready_d = state_d == IDLE;
    valid_d = state_d == DONE;
    busy_d  = state_d == SHIFT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end
  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign bcd_out   = bcd_q;
endmodule

// File: tb/tb_product_bcd_converter.sv
// tb_product_bcd_converter: randomized and directed checks of product_bcd_converter against a decimal model.
module tb_product_bcd_converter;
  logic clk = 0, rst, in_valid, out_ready, in_ready, out_valid, busy;
  logic [7:0] in_bin;
  logic [11:0] bcd_out;
  int checks = 0, errors = 0, cyc = 0, en = 0;
  int m_phase = 0, m_cnt = 0, m_val = 0;
  logic [11:0] m_bcd = 0;
  product_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bin(in_bin), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .bcd_out(bcd_out), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  // phase 0 idle, 1 converting, 2 holding result
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_phase <= 0;
      m_bcd   <= 0;
    end else if (m_phase == 0) begin
      if (in_valid) begin
        m_val   <= int'(in_bin);
        m_cnt   <= 0;
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 7) begin
        m_phase <= 2;
        m_bcd   <= to_bcd(m_val);
      end
    end else if (out_ready) m_phase <= 0;
  end
  always @(negedge clk) if (en != 0) begin
    chk("in_ready", in_ready, m_phase == 0);
    chk("out_valid", out_valid, m_phase == 2);
    chk("busy", busy, m_phase == 1);
    chk("bcd_out", bcd_out, m_bcd);
  end
  task automatic send(input int v);
    int n = 0;
    in_bin = 8'(v);
    in_valid = 1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("accept_timeout", 0, 1);
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic await_res(input logic [11:0] exp, input int hold);
    int n = 0, bc = int'(busy);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
      if (busy) bc++;
    end
    chk("latency", n, 8);
    chk("busy_cycles", bc, 8);
    chk("result", bcd_out, exp);
    if (hold > 0) begin
      out_ready = 0;
      repeat (hold) begin
        @(negedge clk);
        chk("hold_bcd", bcd_out, exp);
        chk("hold_valid", out_valid, 1);
        chk("hold_ready", in_ready, 0);
      end
      out_ready = 1;
    end
    @(negedge clk);
    chk("back_idle", in_ready, 1);
  endtask
  initial begin
    #1000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
  initial begin
    int last = 0, n;
    rst = 1; in_valid = 0; in_bin = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bcd", bcd_out, 0);
    rst = 0;
    en = 1;
    send(12);  await_res(12'h012, 0);
    send(225); await_res(12'h225, 0);
    send(255); await_res(12'h255, 0);
    send(0);   await_res(12'h000, 0);
    send(9);   await_res(12'h009, 0);
    send(100); await_res(12'h100, 0);
    send(144); await_res(12'h144, 5);
    in_bin = 37; in_valid = 1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    in_bin = 99;
    await_res(12'h037, 0);
    @(negedge clk);
    in_valid = 0;
    await_res(12'h099, 0);
    send(200);
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_bcd", bcd_out, 0);
    send(56); await_res(12'h056, 0);
    in_valid = 1;
    for (int v = 0; v < 256; v++) begin
      in_bin = 8'(v);
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("sweep_timeout", 0, 1);
      @(negedge clk);
      if (v > 0) chk("sweep_gap", cyc - last, 10);
      last = cyc;
    end
    in_valid = 0;
    await_res(12'h255, 0);
    for (int k = 0; k < 40; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      send(int'($urandom_range(0, 255)));
      n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      out_ready = 1;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
